// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer.
// Holds the match-phase encoding, the score width and the default winning score.
package pong_pkg;

  localparam int unsigned SCORE_W           = 4;
  localparam int unsigned MAX_SCORE_DEFAULT = 11;

  // Match phases; PAUSED is only reachable when PONG_PAUSE_EN is defined
  typedef enum logic [2:0] {
    STARTUP    = 3'd0,
    SERVE_WAIT = 3'd1,
    SERVE      = 3'd2,
    RALLY      = 3'd3,
    POINT      = 3'd4,
    GAME_OVER  = 3'd5,
    PAUSED     = 3'd6
  } state_e;

endpackage

// File: rtl/pong_btn_arm.sv
// Release-then-press detector for the player buttons.
// A press is accepted only after the buttons have been seen released at least
// once since clr was last asserted, so a button held across a phase change is
// never taken as a new press.
// Ports:
//   clk_0   - clock
//   rst     - synchronous active-high reset
//   clr     - hold high while presses must not be evaluated; clears armed
//   any_btn - high while any player button is pressed
//   armed   - registered: a release has been observed since clr dropped
//   accept  - combinational one-cycle strobe: armed and a button is pressed
module pong_btn_arm
  import pong_pkg::*;
(
  input  logic clk_0,
  input  logic rst,
  input  logic clr,
  input  logic any_btn,
  output logic armed,
  output logic accept
);

  logic armed_q;
  logic armed_d;

  // Arm on the first cycle with all buttons released
  always_comb begin
    armed_d = armed_q;
    if (clr) begin
      armed_d = 1'b0;
    end else if (!any_btn) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

  assign armed  = armed_q;
  assign accept = armed_q & any_btn & ~clr;

endmodule

// File: rtl/pong_match_sequencer.sv
// Match-level controller for the Pong physics datapath: startup lockout,
// serve delay, rally, point award, game over and optional pause.
// Optional feature macro: PONG_PAUSE_EN (adds the PAUSED state driven by
// falling edges of pause_n; when undefined pause_n is unused).
// Ports:
//   clk_0, rst                         - clock, synchronous active-high reset
//   up_p1/down_p1/up_p2/down_p2        - active-low player buttons
//   pause_n                            - active-low pause button
//   miss_left / miss_right             - square left the field (P2 / P1 scores)
//   physics_en                         - physics may move sprites (RALLY)
//   serve_pulse, serve_dir             - re-centre strobe and serve direction
//   sq_shown                           - square visible
//   score_p1, score_p2                 - current scores
//   game_startup, game_over, winner    - match status
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 2_500_000,
  parameter int unsigned SERVE_DELAY    = 50_350_000,
  parameter int unsigned MAX_SCORE      = MAX_SCORE_DEFAULT,
  parameter int unsigned CNT_W          = 27
) (
  input  logic               clk_0,
  input  logic               rst,
  input  logic               up_p1,
  input  logic               down_p1,
  input  logic               up_p2,
  input  logic               down_p2,
  input  logic               pause_n,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               physics_en,
  output logic               serve_pulse,
  output logic               serve_dir,
  output logic               sq_shown,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_startup,
  output logic               game_over,
  output logic               winner
);

  localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_done_q, lock_done_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic               dir_q, dir_d;
  logic               win_q, win_d;
  logic               phys_q, pulse_q, shown_q, start_q, over_q;

  logic any_btn_c;
  logic arm_clr_c;
  logic accept_c;
  logic unused_armed;
  logic pause_fall_c;

  assign any_btn_c = ~(up_p1 & down_p1 & up_p2 & down_p2);

  // Presses are only evaluated after the lockout or while the match is over
  assign arm_clr_c = ~(((state_q == STARTUP) && lock_done_q) || (state_q == GAME_OVER));

  pong_btn_arm u_btn_arm (
    .clk_0   (clk_0),
    .rst     (rst),
    .clr     (arm_clr_c),
    .any_btn (any_btn_c),
    .armed   (unused_armed),
    .accept  (accept_c)
  );

`ifdef PONG_PAUSE_EN
  logic pause_q;

  // Previous pause_n level; reset to released so reset never fakes an edge
  always_ff @(posedge clk_0) begin
    if (rst) begin
      pause_q <= 1'b1;
    end else begin
      pause_q <= pause_n;
    end
  end

  assign pause_fall_c = pause_q & ~pause_n;
`else
  logic unused_pause;
  assign unused_pause = pause_n;
  assign pause_fall_c = 1'b0;
`endif

  // Next-state, counter and score logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    lock_done_d = lock_done_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    dir_d       = dir_q;
    win_d       = win_q;

    case (state_q)
      STARTUP: begin
        if (cnt_q == LOCK_LAST) begin
          cnt_d       = cnt_q;
          lock_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (accept_c) begin
          state_d = SERVE_WAIT;
          cnt_d   = '0;
          p1_d    = '0;
          p2_d    = '0;
          dir_d   = 1'b0;
          win_d   = 1'b0;
        end
      end

      SERVE_WAIT: begin
        if (cnt_q == SERVE_LAST) begin
          state_d = SERVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SERVE: begin
        state_d = RALLY;
      end

      RALLY: begin
        if (miss_left && miss_right) begin
          // Simultaneous exits are a let: re-serve in the same direction
          state_d = SERVE_WAIT;
        end else if (miss_right) begin
          state_d = POINT;
          p1_d    = (p1_q == SCORE_MAX) ? p1_q : p1_q + SCORE_W'(1);
          dir_d   = 1'b0;
        end else if (miss_left) begin
          state_d = POINT;
          p2_d    = (p2_q == SCORE_MAX) ? p2_q : p2_q + SCORE_W'(1);
          dir_d   = 1'b1;
        end else if (pause_fall_c) begin
          state_d = PAUSED;
        end
      end

      POINT: begin
        if (p1_q == SCORE_MAX) begin
          state_d = GAME_OVER;
          win_d   = 1'b0;
        end else if (p2_q == SCORE_MAX) begin
          state_d = GAME_OVER;
          win_d   = 1'b1;
        end else begin
          state_d = SERVE_WAIT;
        end
      end

      GAME_OVER: begin
        if (accept_c) begin
          state_d = SERVE_WAIT;
          p1_d    = '0;
          p2_d    = '0;
          dir_d   = 1'b0;
          win_d   = 1'b0;
        end
      end

`ifdef PONG_PAUSE_EN
      PAUSED: begin
        if (pause_fall_c) begin
          state_d = RALLY;
        end
      end
`endif

      default: begin
        state_d = STARTUP;
      end
    endcase
  end

  // State, datapath and registered phase outputs
  always_ff @(posedge clk_0) begin
    if (rst) begin
      state_q     <= STARTUP;
      cnt_q       <= '0;
      lock_done_q <= 1'b0;
      p1_q        <= '0;
      p2_q        <= '0;
      dir_q       <= 1'b0;
      win_q       <= 1'b0;
      phys_q      <= 1'b0;
      pulse_q     <= 1'b0;
      shown_q     <= 1'b0;
      start_q     <= 1'b1;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_done_q <= lock_done_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      dir_q       <= dir_d;
      win_q       <= win_d;
      phys_q      <= (state_d == RALLY);
      pulse_q     <= (state_d == SERVE);
      shown_q     <= (state_d == SERVE) || (state_d == RALLY) || (state_d == PAUSED);
      start_q     <= (state_d == STARTUP);
      over_q      <= (state_d == GAME_OVER);
    end
  end

  assign physics_en   = phys_q;
  assign serve_pulse  = pulse_q;
  assign serve_dir    = dir_q;
  assign sq_shown     = shown_q;
  assign score_p1     = p1_q;
  assign score_p2     = p2_q;
  assign game_startup = start_q;
  assign game_over    = over_q;
  assign winner       = win_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Table-driven bench for pong_match_sequencer (LOCKOUT=8, SERVE_DELAY=16, MAX_SCORE=3).
module tb_pong_match_sequencer;

  localparam int unsigned LOCK = 8;
  localparam int unsigned SD   = 16;
  localparam int unsigned MAXS = 3;
  localparam int unsigned CW   = 27;

  localparam logic [3:0] IDLE = 4'b1111;
  localparam logic [3:0] PRS  = 4'b1110;
  localparam logic [3:0] PRS2 = 4'b0111;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b1;
  logic       up_p1 = 1'b1, down_p1 = 1'b1, up_p2 = 1'b1, down_p2 = 1'b1;
  logic       pause_n = 1'b1;
  logic       miss_left = 1'b0, miss_right = 1'b0;
  logic       physics_en, serve_pulse, serve_dir, sq_shown;
  logic [3:0] score_p1, score_p2;
  logic       game_startup, game_over, winner;

  always #5 clk_0 = ~clk_0;

  pong_match_sequencer #(
    .LOCKOUT_CYCLES (LOCK),
    .SERVE_DELAY    (SD),
    .MAX_SCORE      (MAXS),
    .CNT_W          (CW)
  ) dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .up_p1        (up_p1),
    .down_p1      (down_p1),
    .up_p2        (up_p2),
    .down_p2      (down_p2),
    .pause_n      (pause_n),
    .miss_left    (miss_left),
    .miss_right   (miss_right),
    .physics_en   (physics_en),
    .serve_pulse  (serve_pulse),
    .serve_dir    (serve_dir),
    .sq_shown     (sq_shown),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .game_startup (game_startup),
    .game_over    (game_over),
    .winner       (winner)
  );

  typedef enum int {PH_START, PH_SW, PH_SERVE, PH_RALLY, PH_POINT, PH_OVER, PH_PAUSE} phase_e;

  typedef struct {
    logic       r;
    logic [3:0] btn;
    logic       ml;
    logic       mr;
    logic       pz;
    int         n;
    phase_e     ph;
    logic       dir;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       win;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(logic r, logic [3:0] btn, logic ml, logic mr, logic pz, int n,
                              phase_e ph, logic dir, int s1, int s2, logic win);
    vec_t v;
    v.r = r; v.btn = btn; v.ml = ml; v.mr = mr; v.pz = pz; v.n = n;
    v.ph = ph; v.dir = dir; v.s1 = 4'(s1); v.s2 = 4'(s2); v.win = win;
    vq.push_back(v);
  endfunction

  // Remainder of a serve delay after the SERVE_WAIT entry cycle, then serve and rally
  function automatic void add_wait(logic dir, int s1, int s2, logic win);
    add(0, IDLE, 0, 0, 1, 15, PH_SW,    dir, s1, s2, win);
    add(0, IDLE, 0, 0, 1, 1,  PH_SERVE, dir, s1, s2, win);
    add(0, IDLE, 0, 0, 1, 1,  PH_RALLY, dir, s1, s2, win);
  endfunction

  task automatic chk(input int row, input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL row %0d %s got=%0h exp=%0h", row, nm, got, exp);
    end
  endtask

  initial begin
    // Button held from reset through the lockout is never accepted
    add(1, PRS,  0, 0, 1, 2,  PH_START, 0, 0, 0, 0);
    add(0, PRS,  0, 0, 1, 30, PH_START, 0, 0, 0, 0);
    add(0, IDLE, 0, 0, 1, 1,  PH_START, 0, 0, 0, 0);
    add(0, PRS,  0, 0, 1, 1,  PH_SW,    0, 0, 0, 0);
    add_wait(0, 0, 0, 0);
    // P1 point
    add(0, IDLE, 0, 1, 1, 1, PH_POINT, 0, 1, 0, 0);
    add(0, IDLE, 0, 0, 1, 1, PH_SW,    0, 1, 0, 0);
    add_wait(0, 1, 0, 0);
    // P2 point
    add(0, IDLE, 1, 0, 1, 1, PH_POINT, 1, 1, 1, 0);
    add(0, IDLE, 0, 0, 1, 1, PH_SW,    1, 1, 1, 0);
    add_wait(1, 1, 1, 0);
    // Double miss, then a miss during SERVE_WAIT is ignored
    add(0, IDLE, 1, 1, 1, 1,  PH_SW,    1, 1, 1, 0);
    add(0, IDLE, 0, 1, 1, 1,  PH_SW,    1, 1, 1, 0);
    add(0, IDLE, 0, 0, 1, 14, PH_SW,    1, 1, 1, 0);
    add(0, IDLE, 0, 0, 1, 1,  PH_SERVE, 1, 1, 1, 0);
    add(0, IDLE, 0, 0, 1, 1,  PH_RALLY, 1, 1, 1, 0);
    // P2 wins with a button held into GAME_OVER
    add(0, IDLE, 1, 0, 1, 1, PH_POINT, 1, 1, 2, 0);
    add(0, IDLE, 0, 0, 1, 1, PH_SW,    1, 1, 2, 0);
    add_wait(1, 1, 2, 0);
    add(0, PRS,  1, 0, 1, 1,  PH_POINT, 1, 1, 3, 0);
    add(0, PRS,  0, 0, 1, 1,  PH_OVER,  1, 1, 3, 1);
    add(0, PRS,  0, 0, 1, 10, PH_OVER,  1, 1, 3, 1);
    add(0, IDLE, 1, 1, 1, 1,  PH_OVER,  1, 1, 3, 1);
    add(0, PRS2, 0, 0, 1, 1,  PH_SW,    0, 0, 0, 0);
    add_wait(0, 0, 0, 0);
    // P1 wins with three miss_right pulses
    for (int k = 1; k <= 3; k++) begin
      add(0, IDLE, 0, 1, 1, 1, PH_POINT, 0, k, 0, 0);
      if (k < 3) begin
        add(0, IDLE, 0, 0, 1, 1, PH_SW, 0, k, 0, 0);
        add_wait(0, k, 0, 0);
      end
    end
    add(0, IDLE, 0, 0, 1, 1, PH_OVER, 0, 3, 0, 0);
    // Reset in GAME_OVER clears everything
    add(1, IDLE, 0, 0, 1, 1, PH_START, 0, 0, 0, 0);
    // Press during lockout cycles 5..6, released at 7, then a fresh press
    add(1, IDLE, 0, 0, 1, 1, PH_START, 0, 0, 0, 0);
    add(0, IDLE, 0, 0, 1, 5, PH_START, 0, 0, 0, 0);
    add(0, PRS,  0, 0, 1, 2, PH_START, 0, 0, 0, 0);
    add(0, IDLE, 0, 0, 1, 1, PH_START, 0, 0, 0, 0);
    add(0, IDLE, 0, 0, 1, 1, PH_START, 0, 0, 0, 0);
    add(0, PRS,  0, 0, 1, 1, PH_SW,    0, 0, 0, 0);
`ifdef PONG_PAUSE_EN
    add_wait(0, 0, 0, 0);
    add(0, IDLE, 0, 1, 1, 1, PH_POINT, 0, 1, 0, 0);
    add(0, IDLE, 0, 0, 1, 1, PH_SW,    0, 1, 0, 0);
    add_wait(0, 1, 0, 0);
    add(0, IDLE, 0, 0, 0, 1, PH_PAUSE, 0, 1, 0, 0);
    add(0, IDLE, 1, 0, 0, 1, PH_PAUSE, 0, 1, 0, 0);
    add(0, IDLE, 0, 0, 1, 2, PH_PAUSE, 0, 1, 0, 0);
    add(0, IDLE, 0, 0, 0, 1, PH_RALLY, 0, 1, 0, 0);
    add(0, IDLE, 0, 0, 1, 1, PH_RALLY, 0, 1, 0, 0);
    // Miss beats a pause edge in the same cycle
    add(0, IDLE, 1, 0, 0, 1, PH_POINT, 1, 1, 1, 0);
    add(0, IDLE, 0, 0, 1, 1, PH_SW,    1, 1, 1, 0);
    add_wait(1, 1, 1, 0);
    add(0, IDLE, 0, 0, 0, 1, PH_PAUSE, 1, 1, 1, 0);
    add(1, IDLE, 0, 0, 0, 1, PH_START, 0, 0, 0, 0);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      rst        = vq[i].r;
      {up_p1, down_p1, up_p2, down_p2} = vq[i].btn;
      miss_left  = vq[i].ml;
      miss_right = vq[i].mr;
      pause_n    = vq[i].pz;
      repeat (vq[i].n) @(posedge clk_0);
      #1;
      chk(i, "physics_en",   {3'b0, physics_en},   {3'b0, vq[i].ph == PH_RALLY});
      chk(i, "sq_shown",     {3'b0, sq_shown},
          {3'b0, (vq[i].ph == PH_SERVE) || (vq[i].ph == PH_RALLY) || (vq[i].ph == PH_PAUSE)});
      chk(i, "serve_pulse",  {3'b0, serve_pulse},  {3'b0, vq[i].ph == PH_SERVE});
      chk(i, "game_startup", {3'b0, game_startup}, {3'b0, vq[i].ph == PH_START});
      chk(i, "game_over",    {3'b0, game_over},    {3'b0, vq[i].ph == PH_OVER});
      chk(i, "serve_dir",    {3'b0, serve_dir},    {3'b0, vq[i].dir});
      chk(i, "score_p1",     score_p1,             vq[i].s1);
      chk(i, "score_p2",     score_p2,             vq[i].s2);
      chk(i, "winner",       {3'b0, winner},       {3'b0, vq[i].win});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
